dphy_hstx_byte_feeder: RTL and testbench

Byte-clock-domain packet buffer and sequencer sitting directly upstream of the HS transmitter (`DPHY_HSTX`). It accepts packet bytes from the protocol layer over a valid/ready interface and stores them in a small FIFO. It then drives the HS transmitter's `TxValid`/`SOT`/`TxByte_Data`/`TxReady` handshake, one uninterrupted burst per packet. It enforces an inter-burst gap, and aborts a burst cleanly if the FIFO runs dry mid-packet, because HS bursts cannot stall.

---
 rtl/dphy_hstx_byte_feeder_if.sv | 27 ++
 rtl/dphy_hstx_byte_feeder.sv | 117 +++++++++++
 tb/tb_dphy_hstx_byte_feeder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dphy_hstx_byte_feeder_if.sv
// Byte-stream handshake bundle between the protocol layer, the feeder
// and the HS transmitter.
`timescale 1ns/1ps
interface dphy_hstx_byte_feeder_if;
  logic       InValid;
  logic [7:0] InData;
  logic       InLast;
  logic       InReady;
  logic       TxValid;
  logic       SOT;
  logic [7:0] TxByte_Data;
  logic       TxReady;
  logic       Busy;
  logic       UnderflowErr;

  modport master (
    output InValid, InData, InLast, TxReady,
    input  InReady, TxValid, SOT, TxByte_Data,
    input  Busy, UnderflowErr
  );

  modport slave (
    input  InValid, InData, InLast, TxReady,
    output InReady, TxValid, SOT, TxByte_Data,
    output Busy, UnderflowErr
  );
endinterface

// File: rtl/dphy_hstx_byte_feeder.sv
// Packet FIFO plus burst sequencer feeding the D-PHY HS transmitter.
// Bursts never stall, so a mid-packet FIFO underrun drops the packet tail.
`timescale 1ns/1ps
module dphy_hstx_byte_feeder #(
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 4
) (
  input logic TxByteClkHS,
  input logic TxRst,
  dphy_hstx_byte_feeder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LP_ONE = (AW+1)'(1);
  localparam logic [GW-1:0] LP_GAP = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_DROP, S_GAP
  } state_t;

  state_t r_state, w_next;
  logic [8:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count, r_pkt_cnt;
  logic [GW-1:0] r_gap;
  logic r_underflow;

  logic w_full, w_empty, w_wr, w_pop, w_abort;
  logic w_txvalid, w_pkt_inc, w_pkt_dec;
  logic [8:0] w_head;

  assign w_full = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_head = r_mem[r_rptr];
  assign w_wr = bus.InValid && !w_full;
  assign w_txvalid = (r_state == S_START) || (r_state == S_DATA);
  assign w_pkt_inc = w_wr && bus.InLast;
  assign w_pkt_dec = w_pop && w_head[8];

  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (r_pkt_cnt != '0 || w_full) w_next = S_START;
      S_START, S_DATA:
        if (bus.TxReady && !w_empty) begin
          w_pop = 1'b1;
          if (w_head[8]) begin
            w_next = S_GAP;
          end else if (r_count == LP_ONE && !w_wr) begin
            w_next = S_DROP;
            w_abort = 1'b1;
          end else begin
            w_next = S_DATA;
          end
        end
      S_DROP:
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[8]) w_next = S_GAP;
        end
      S_GAP:
        if (r_gap == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst) begin
      r_state <= S_IDLE;
      r_underflow <= 1'b0;
      r_gap <= '0;
    end else begin
      r_state <= w_next;
      r_underflow <= w_abort;
      if (w_next == S_GAP && r_state != S_GAP)
        r_gap <= LP_GAP;
      else if (r_state == S_GAP && r_gap != '0)
        r_gap <= r_gap - GW'(1);
    end
  end

  always_ff @(posedge TxByteClkHS or posedge TxRst) begin
    if (TxRst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)
        r_count <= r_count + LP_ONE;
      else if (!w_wr && w_pop)
        r_count <= r_count - LP_ONE;
      if (w_pkt_inc && !w_pkt_dec)
        r_pkt_cnt <= r_pkt_cnt + LP_ONE;
      else if (!w_pkt_inc && w_pkt_dec)
        r_pkt_cnt <= r_pkt_cnt - LP_ONE;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge TxByteClkHS) begin
    if (w_wr) r_mem[r_wptr] <= {bus.InLast, bus.InData};
  end

  assign bus.TxValid = w_txvalid;
  assign bus.SOT = w_txvalid;
  assign bus.TxByte_Data = w_txvalid ? w_head[7:0] : 8'h00;
  assign bus.InReady = !w_full;
  assign bus.Busy = (r_state != S_IDLE);
  assign bus.UnderflowErr = r_underflow;
endmodule

// File: tb/tb_dphy_hstx_byte_feeder.sv
// Directed and randomized bench for dphy_hstx_byte_feeder, checked
// against a packet-level queue model of the expected HS byte stream.
`timescale 1ns/1ps
module tb_dphy_hstx_byte_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dphy_hstx_byte_feeder_if bus ();

  dphy_hstx_byte_feeder #(
    .FIFO_DEPTH(8),
    .GAP_CYCLES(4)
  ) dut (
    .TxByteClkHS(clk),
    .TxRst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int len_q [$];
  bit mon_prev = 1'b0;
  int mon_cnt = 0;
  bit wr_done = 1'b0;

  task automatic chk(input string tag, input logic [8:0] obs,
                     input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic l);
    int n = 0;
    bus.InValid = 1'b1;
    bus.InData = d;
    bus.InLast = l;
    while (!bus.InReady && n < 100) begin
      tick();
      n++;
    end
    chk("wr_ready", {8'h0, bus.InReady}, 9'h1);
    tick();
    bus.InValid = 1'b0;
    bus.InLast = 1'b0;
    bus.InData = 8'h00;
  endtask

  task automatic expect_pkt(input logic [7:0] b [$]);
    len_q.push_back(b.size());
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.Busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", {8'h0, bus.Busy}, 9'h0);
    chk("model_drained", 9'(exp_q.size()), 9'h0);
  endtask

  initial begin
    logic [7:0] pk [$];
    int low;
    int n;
    bus.InValid = 1'b0;
    bus.InData = 8'h00;
    bus.InLast = 1'b0;
    bus.TxReady = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          mon_prev = 1'b0;
          mon_cnt = 0;
        end else begin
          chk("sot_eq_valid", {8'h0, bus.SOT}, {8'h0, bus.TxValid});
          if (bus.TxValid && bus.TxReady) begin
            chk("byte_expected", {8'h0, exp_q.size() != 0}, 9'h1);
            if (exp_q.size() != 0)
              chk("tx_byte", {1'b0, bus.TxByte_Data},
                  {1'b0, exp_q.pop_front()});
            mon_cnt++;
          end else if (!bus.TxValid) begin
            chk("idle_data", {1'b0, bus.TxByte_Data}, 9'h0);
          end
          if (mon_prev && !bus.TxValid) begin
            chk("burst_expected", {8'h0, len_q.size() != 0}, 9'h1);
            if (len_q.size() != 0)
              chk("burst_len", 9'(mon_cnt), 9'(len_q.pop_front()));
            mon_cnt = 0;
          end
          mon_prev = bus.TxValid;
        end
      end
      begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    #1;
    chk("rst_txvalid", {8'h0, bus.TxValid}, 9'h0);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_sot", {8'h0, bus.SOT}, 9'h0);
    chk("rst_data", {1'b0, bus.TxByte_Data}, 9'h0);
    chk("rst_inready", {8'h0, bus.InReady}, 9'h1);
    chk("rst_busy", {8'h0, bus.Busy}, 9'h0);
    chk("rst_uf", {8'h0, bus.UnderflowErr}, 9'h0);

    // Single packet, start latency and gap length
    bus.TxReady = 1'b1;
    pk = '{8'hA5, 8'h3C, 8'h7E, 8'h99};
    expect_pkt(pk);
    wr(8'hA5, 1'b0);
    wr(8'h3C, 1'b0);
    wr(8'h7E, 1'b0);
    wr(8'h99, 1'b1);
    chk("single_pre_start", {8'h0, bus.TxValid}, 9'h0);
    tick();
    chk("single_valid", {8'h0, bus.TxValid}, 9'h1);
    chk("single_b0", {1'b0, bus.TxByte_Data}, 9'hA5);
    tick();
    chk("single_b1", {1'b0, bus.TxByte_Data}, 9'h3C);
    tick();
    chk("single_b2", {1'b0, bus.TxByte_Data}, 9'h7E);
    tick();
    chk("single_b3", {1'b0, bus.TxByte_Data}, 9'h99);
    tick();
    chk("single_end", {8'h0, bus.TxValid}, 9'h0);
    chk("single_gap_busy0", {8'h0, bus.Busy}, 9'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("single_gap_busy", {8'h0, bus.Busy}, 9'h1);
    end
    tick();
    chk("single_busy_done", {8'h0, bus.Busy}, 9'h0);

    // Stall in START
    bus.TxReady = 1'b0;
    pk = '{8'hA5, 8'hB6};
    expect_pkt(pk);
    wr(8'hA5, 1'b0);
    wr(8'hB6, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", {8'h0, bus.TxValid}, 9'h1);
      chk("stall_data", {1'b0, bus.TxByte_Data}, 9'hA5);
      tick();
    end
    bus.TxReady = 1'b1;
    wait_idle(50);

    // Full without last, then underflow and drop
    pk.delete();
    for (int i = 0; i < 8; i++) pk.push_back(8'(i));
    expect_pkt(pk);
    for (int i = 0; i < 8; i++) wr(8'(i), 1'b0);
    chk("full_inready", {8'h0, bus.InReady}, 9'h0);
    n = 0;
    while (!bus.UnderflowErr && n < 40) begin
      tick();
      n++;
    end
    chk("uf_pulse", {8'h0, bus.UnderflowErr}, 9'h1);
    chk("uf_txvalid", {8'h0, bus.TxValid}, 9'h0);
    tick();
    chk("uf_one_cycle", {8'h0, bus.UnderflowErr}, 9'h0);
    wr(8'h08, 1'b0);
    wr(8'h09, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_busy", {8'h0, bus.Busy}, 9'h1);
    end
    tick();
    chk("drop_busy_done", {8'h0, bus.Busy}, 9'h0);
    chk("drop_no_burst", {8'h0, bus.TxValid}, 9'h0);

    // Back-to-back packets
    bus.TxReady = 1'b0;
    pk = '{8'h11, 8'h22};
    expect_pkt(pk);
    pk = '{8'h33, 8'h44};
    expect_pkt(pk);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b0);
    wr(8'h44, 1'b1);
    bus.TxReady = 1'b1;
    n = 0;
    while (bus.TxValid && n < 20) begin
      tick();
      n++;
    end
    low = 0;
    while (!bus.TxValid && low < 50) begin
      low++;
      tick();
    end
    chk("b2b_gap", 9'(low), 9'd5);
    wait_idle(50);

    // Write on the same edge as the last-byte pop
    pk = '{8'h55, 8'h66};
    expect_pkt(pk);
    pk = '{8'h77, 8'h88};
    expect_pkt(pk);
    wr(8'h55, 1'b0);
    wr(8'h66, 1'b1);
    tick();
    chk("conc_b0", {1'b0, bus.TxByte_Data}, 9'h55);
    tick();
    chk("conc_b1", {1'b0, bus.TxByte_Data}, 9'h66);
    wr(8'h77, 1'b0);
    chk("conc_end", {8'h0, bus.TxValid}, 9'h0);
    chk("conc_uf", {8'h0, bus.UnderflowErr}, 9'h0);
    wr(8'h88, 1'b1);
    wait_idle(50);

    // Reset mid-burst
    bus.TxReady = 1'b0;
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b1);
    tick();
    chk("mid_pre", {8'h0, bus.TxValid}, 9'h1);
    rst = 1'b1;
    #1;
    chk("mid_txvalid", {8'h0, bus.TxValid}, 9'h0);
    chk("mid_sot", {8'h0, bus.SOT}, 9'h0);
    chk("mid_data", {1'b0, bus.TxByte_Data}, 9'h0);
    chk("mid_inready", {8'h0, bus.InReady}, 9'h1);
    chk("mid_busy", {8'h0, bus.Busy}, 9'h0);
    exp_q.delete();
    len_q.delete();
    tick();
    rst = 1'b0;
    bus.TxReady = 1'b1;
    repeat (6) tick();
    chk("mid_empty_valid", {8'h0, bus.TxValid}, 9'h0);
    chk("mid_empty_busy", {8'h0, bus.Busy}, 9'h0);

    // Randomized packets with random TxReady back-pressure
    wr_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          int len;
          len = $urandom_range(1, 8);
          pk.delete();
          for (int b = 0; b < len; b++) pk.push_back(8'($urandom));
          expect_pkt(pk);
          for (int b = 0; b < len; b++) begin
            wr(pk[b], b == len - 1);
            repeat ($urandom_range(0, 2)) tick();
          end
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          @(posedge clk);
          #2;
          bus.TxReady = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.TxReady = 1'b1;
    wait_idle(400);
    chk("rand_no_uf", {8'h0, bus.UnderflowErr}, 9'h0);
    chk("rand_bursts_done", 9'(len_q.size()), 9'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
